rvvi_retire_arbiter: RTL

Collects per-hart retirement records from NHART hart trace ports and serialises them into one RVVI-format event stream for the host-side trace consumer. Each hart has its own record FIFO. A round-robin arbiter picks which hart drains into a registered output stage. The block also checks that each hart's order count is gap-free, and stops accepting records from a hart once that hart halts.

---
 rtl/rvvi_retire_arbiter_if.sv | 46 ++++
 rtl/rvvi_retire_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rvvi_retire_arbiter_if.sv
// Bundle of per-hart retirement trace inputs, the serialised RVVI output
// stream and the per-hart status flags of the retirement arbiter.
interface rvvi_retire_arbiter_if #(
    parameter int ILEN  = 32,
    parameter int XLEN  = 32,
    parameter int NHART = 2,
    parameter int HW    = (NHART > 1) ? $clog2(NHART) : 1
);
    // Per-hart retirement input side
    logic [NHART-1:0]      in_valid;
    logic [NHART-1:0]      in_ready;
    logic [NHART*64-1:0]   in_order;
    logic [NHART*XLEN-1:0] in_pc;
    logic [NHART*ILEN-1:0] in_insn;
    logic [NHART-1:0]      in_trap;
    logic [NHART-1:0]      in_halt;

    // Serialised output stream
    logic                  out_valid;
    logic                  out_ready;
    logic [HW-1:0]         out_hart;
    logic [63:0]           out_order;
    logic [XLEN-1:0]       out_pc;
    logic [ILEN-1:0]       out_insn;
    logic                  out_trap;
    logic                  out_halt;

    // Status
    logic [NHART-1:0]      halted;
    logic [NHART-1:0]      order_err;
    logic                  err_pulse;

    // Arbiter side
    modport slave (
        input  in_valid, in_order, in_pc, in_insn, in_trap, in_halt, out_ready,
        output in_ready, out_valid, out_hart, out_order, out_pc, out_insn,
               out_trap, out_halt, halted, order_err, err_pulse
    );

    // Trace producer / consumer side
    modport master (
        output in_valid, in_order, in_pc, in_insn, in_trap, in_halt, out_ready,
        input  in_ready, out_valid, out_hart, out_order, out_pc, out_insn,
               out_trap, out_halt, halted, order_err, err_pulse
    );
endinterface

// File: rtl/rvvi_retire_arbiter.sv
// Serialises per-hart retirement records into a single RVVI event stream.
// Each hart owns a small record FIFO; a round-robin arbiter drains the
// FIFOs into one registered output stage. Order counts are checked for
// gaps per hart, and a hart stops being accepted once it retires a halt.
module rvvi_retire_arbiter #(
    parameter int ILEN  = 32,
    parameter int XLEN  = 32,
    parameter int NHART = 2,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rvvi_retire_arbiter_if.slave bus
);

    localparam int HW     = (NHART > 1) ? $clog2(NHART) : 1;
    localparam int AW     = $clog2(DEPTH);
    // Record layout: {halt, trap, insn, pc, order}
    localparam int RW     = 64 + XLEN + ILEN + 2;
    localparam int O_PC   = 64;
    localparam int O_INSN = 64 + XLEN;
    localparam int O_TRAP = 64 + XLEN + ILEN;
    localparam int O_HALT = O_TRAP + 1;

    logic [NHART-1:0] in_ready;
    logic [NHART-1:0] fifo_empty;
    logic [NHART-1:0] fifo_full;
    logic [NHART-1:0] halted;
    logic [NHART-1:0] order_err;
    logic [NHART-1:0] mismatch;
    logic [RW-1:0]    head_rec [NHART];

    logic             grant_valid;
    logic [HW-1:0]    grant_idx;
    logic             load_en;
    logic [RW-1:0]    grant_rec;

    logic [HW-1:0]    rr_ptr_q;
    logic             out_valid_q;
    logic [HW-1:0]    out_hart_q;
    logic [RW-1:0]    out_rec_q;
    logic             err_pulse_q;

    // The output stage can take a new record when empty or being consumed.
    assign load_en = !out_valid_q || bus.out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NHART; gi++) begin : g_hart
            logic [RW-1:0] mem_q [DEPTH];
            logic [AW-1:0] wr_ptr_q;
            logic [AW-1:0] rd_ptr_q;
            logic [AW:0]   cnt_q;
            logic          seen_q;
            logic [63:0]   expected_q;
            logic          halted_q;
            logic          order_err_q;
            logic          push;
            logic          pop;
            logic [RW-1:0] in_rec;
            logic [63:0]   rec_order;

            assign rec_order = bus.in_order[gi*64 +: 64];
            assign in_rec    = {bus.in_halt[gi], bus.in_trap[gi],
                                bus.in_insn[gi*ILEN +: ILEN],
                                bus.in_pc[gi*XLEN +: XLEN], rec_order};

            // Ready depends only on registered state, never on the drain side.
            assign fifo_full[gi]  = (cnt_q == (AW+1)'(DEPTH));
            assign fifo_empty[gi] = (cnt_q == '0);
            assign in_ready[gi]   = !fifo_full[gi] && !halted_q;
            assign push           = bus.in_valid[gi] && in_ready[gi];
            assign pop            = grant_valid && load_en && (grant_idx == HW'(gi));
            assign head_rec[gi]   = mem_q[rd_ptr_q];

            // 64-bit wrap is intentional: all-ones followed by zero is legal.
            assign mismatch[gi]   = push && seen_q && (rec_order != expected_q + 64'd1);
            assign halted[gi]     = halted_q;
            assign order_err[gi]  = order_err_q;

            // Record storage; contents need no reset since occupancy gates reads.
            always_ff @(posedge clk) begin
                if (push) begin
                    mem_q[wr_ptr_q] <= in_rec;
                end
            end

            // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    cnt_q    <= '0;
                end else begin
                    if (push) begin
                        wr_ptr_q <= wr_ptr_q + AW'(1);
                    end
                    if (pop) begin
                        rd_ptr_q <= rd_ptr_q + AW'(1);
                    end
                    case ({push, pop})
                        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                        default: cnt_q <= cnt_q;
                    endcase
                end
            end

            // Order tracking, sticky error and sticky halt for this hart.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    seen_q      <= 1'b0;
                    expected_q  <= '0;
                    halted_q    <= 1'b0;
                    order_err_q <= 1'b0;
                end else if (push) begin
                    // Always resynchronise to the latest order count.
                    seen_q     <= 1'b1;
                    expected_q <= rec_order;
                    if (mismatch[gi]) begin
                        order_err_q <= 1'b1;
                    end
                    if (bus.in_halt[gi]) begin
                        halted_q <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Round-robin pick: first non-empty FIFO after the last granted hart.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NHART; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NHART) begin
                idx = idx - NHART;
            end
            if (!grant_valid && !fifo_empty[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = HW'(idx);
            end
        end
    end

    assign grant_rec = head_rec[grant_idx];

    // Output register and round-robin pointer; fields hold while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= HW'(NHART - 1);
            out_valid_q <= 1'b0;
            out_hart_q  <= '0;
            out_rec_q   <= '0;
        end else if (load_en) begin
            out_valid_q <= grant_valid;
            if (grant_valid) begin
                rr_ptr_q   <= grant_idx;
                out_hart_q <= grant_idx;
                out_rec_q  <= grant_rec;
            end
        end
    end

    // One pulse per cycle with any new order error, however many harts hit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= |mismatch;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_hart  = out_hart_q;
    assign bus.out_order = out_rec_q[63:0];
    assign bus.out_pc    = out_rec_q[O_PC +: XLEN];
    assign bus.out_insn  = out_rec_q[O_INSN +: ILEN];
    assign bus.out_trap  = out_rec_q[O_TRAP];
    assign bus.out_halt  = out_rec_q[O_HALT];
    assign bus.halted    = halted;
    assign bus.order_err = order_err;
    assign bus.err_pulse = err_pulse_q;

endmodule
